// File: rtl/ipgu_scale_sched_if.sv
// Host/IPGU/HEU handshake bundle for the IPGU scale scheduler.
// The master side is the scheduler; the slave side is the surrounding system.
interface ipgu_scale_sched_if #(
    parameter int CNT_W = 16
);
    logic             hostReq;
    logic             hostGnt;
    logic             start;
    logic             initIpgu;
    logic             rdyIpgu;
    logic             vldIpgu;
    logic             rdyHeu;
    logic [2:0]       scaleIdx;
    logic [CNT_W-1:0] winCnt;
    logic [CNT_W-1:0] frameWinCnt;
    logic             busy;
    logic             frameDone;
    logic             err;

    modport master (
        input  hostReq, start, rdyIpgu, vldIpgu, rdyHeu,
        output hostGnt, initIpgu, scaleIdx, winCnt, frameWinCnt, busy, frameDone, err
    );

    modport slave (
        output hostReq, start, rdyIpgu, vldIpgu, rdyHeu,
        input  hostGnt, initIpgu, scaleIdx, winCnt, frameWinCnt, busy, frameDone, err
    );
endinterface

// File: rtl/ipgu_scale_sched.sv
// IPGU frame sequencer: RAM1 host/IPGU arbitration, per-scale init pulses, window counting.
// Define SCHED_WDOG_EN to add a stall watchdog on WAITACK/RUN (limit WDOG_CYCLES).
module ipgu_scale_sched #(
    parameter int NUM_SCALES  = 5,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst,
    ipgu_scale_sched_if.master  bus
);
    typedef enum logic [2:0] {IDLE, LOAD, INIT, WAITACK, RUN, NEXT, DONE} state_t;

    localparam logic [2:0] LAST_SCALE = 3'(NUM_SCALES - 1);

    state_t           state_q;
    logic             hostGnt_q;
    logic             initIpgu_q;
    logic             busy_q;
    logic             frameDone_q;
    logic             err_q;
    logic             imgValid_q;
    logic             rdyPrev_q;
    logic [2:0]       scaleIdx_q;
    logic [1:0]       ackCnt_q;
    logic [CNT_W-1:0] winCnt_q;
    logic [CNT_W-1:0] frameWinCnt_q;
    logic [CNT_W-1:0] winCnt_d;
    logic [CNT_W-1:0] frameWinCnt_d;

    logic beat;
    logic rdyRise;
    logic wdogHit;

    assign beat    = bus.vldIpgu & bus.rdyHeu;
    assign rdyRise = bus.rdyIpgu & ~rdyPrev_q;

    always_comb begin
        winCnt_d      = (winCnt_q == '1) ? winCnt_q : winCnt_q + CNT_W'(1);
        frameWinCnt_d = (frameWinCnt_q == '1) ? frameWinCnt_q : frameWinCnt_q + CNT_W'(1);
    end

`ifdef SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q;
    logic              wdogRun;

    // Counter only advances while the FSM is stuck in the same wait state with no progress.
    assign wdogRun = (state_q == WAITACK && bus.rdyIpgu && ackCnt_q != 2'd3)
                  || (state_q == RUN && !beat && !rdyRise);
    assign wdogHit = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !wdogRun) wdog_q <= '0;
        else                 wdog_q <= wdog_q + WDOG_W'(1);
    end
`else
    assign wdogHit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hostGnt_q     <= 1'b0;
            initIpgu_q    <= 1'b0;
            busy_q        <= 1'b0;
            frameDone_q   <= 1'b0;
            err_q         <= 1'b0;
            imgValid_q    <= 1'b0;
            rdyPrev_q     <= 1'b0;
            scaleIdx_q    <= '0;
            ackCnt_q      <= '0;
            winCnt_q      <= '0;
            frameWinCnt_q <= '0;
        end else begin
            initIpgu_q  <= 1'b0;
            frameDone_q <= 1'b0;
            rdyPrev_q   <= bus.rdyIpgu;
            case (state_q)
                IDLE: begin
                    if (bus.hostReq) begin
                        state_q   <= LOAD;
                        hostGnt_q <= 1'b1;
                    end else if (bus.start) begin
                        if (!imgValid_q) begin
                            err_q <= 1'b1;
                        end else if (bus.rdyIpgu) begin
                            state_q       <= INIT;
                            initIpgu_q    <= 1'b1;
                            busy_q        <= 1'b1;
                            scaleIdx_q    <= '0;
                            winCnt_q      <= '0;
                            frameWinCnt_q <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (!bus.hostReq) begin
                        state_q    <= IDLE;
                        hostGnt_q  <= 1'b0;
                        imgValid_q <= 1'b1;
                    end
                end
                INIT: begin
                    state_q  <= WAITACK;
                    ackCnt_q <= '0;
                end
                WAITACK: begin
                    // An IPGU that never drops rdy is taken to have accepted synchronously.
                    if (!bus.rdyIpgu || ackCnt_q == 2'd3) begin
                        state_q <= RUN;
                    end else if (wdogHit) begin
                        state_q    <= IDLE;
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        imgValid_q <= 1'b0;
                    end else begin
                        ackCnt_q <= ackCnt_q + 2'd1;
                    end
                end
                RUN: begin
                    if (beat) begin
                        winCnt_q      <= winCnt_d;
                        frameWinCnt_q <= frameWinCnt_d;
                    end
                    if (rdyRise) begin
                        state_q <= NEXT;
                    end else if (wdogHit && !beat) begin
                        state_q    <= IDLE;
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        imgValid_q <= 1'b0;
                    end
                end
                NEXT: begin
                    if (scaleIdx_q == LAST_SCALE) begin
                        state_q     <= DONE;
                        frameDone_q <= 1'b1;
                        busy_q      <= 1'b0;
                        imgValid_q  <= 1'b0;
                    end else begin
                        state_q    <= INIT;
                        initIpgu_q <= 1'b1;
                        scaleIdx_q <= scaleIdx_q + 3'd1;
                        winCnt_q   <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.hostGnt     = hostGnt_q;
    assign bus.initIpgu    = initIpgu_q;
    assign bus.scaleIdx    = scaleIdx_q;
    assign bus.winCnt      = winCnt_q;
    assign bus.frameWinCnt = frameWinCnt_q;
    assign bus.busy        = busy_q;
    assign bus.frameDone   = frameDone_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ipgu_scale_sched.sv
// Directed bench for ipgu_scale_sched with a small IPGU behavioural model (3 beats per scale).
module tb_ipgu_scale_sched;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ipgu_scale_sched_if #(.CNT_W(CNT_W)) bus ();

    ipgu_scale_sched #(.NUM_SCALES(5), .CNT_W(CNT_W), .WDOG_CYCLES(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic mdl_en   = 1'b1;
    logic mdl_hang = 1'b0;
    logic m_rdy    = 1'b1;
    logic m_vld    = 1'b0;
    logic t_rdy    = 1'b1;
    logic t_vld    = 1'b0;

    assign bus.rdyIpgu = mdl_en ? m_rdy : t_rdy;
    assign bus.vldIpgu = mdl_en ? m_vld : t_vld;

    // IPGU model: accept init, deliver 3 beats, then return to ready.
    initial forever begin
        @(negedge clk);
        if (mdl_en && bus.initIpgu) begin
            m_rdy = 1'b0;
            if (!mdl_hang) begin
                repeat (2) @(negedge clk);
                m_vld = 1'b1;
                repeat (3) @(negedge clk);
                m_vld = 1'b0;
                m_rdy = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_chk++;
        if ({bus.hostGnt, bus.initIpgu, bus.busy, bus.frameDone, bus.err, bus.scaleIdx, bus.winCnt, bus.frameWinCnt} !== '0) begin
            $display("FAIL reset_outputs gnt=%b init=%b busy=%b done=%b err=%b idx=%0d win=%0d fwin=%0d expected all 0",
                     bus.hostGnt, bus.initIpgu, bus.busy, bus.frameDone, bus.err, bus.scaleIdx, bus.winCnt, bus.frameWinCnt);
            n_fail++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_no_load();
        logic saw_init;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        saw_init = bus.initIpgu;
        repeat (3) begin
            tick();
            saw_init |= bus.initIpgu;
        end
        n_chk++;
        if (saw_init !== 1'b0) begin $display("FAIL noload_init got=%b exp=0", saw_init); n_fail++; end
        n_chk++;
        if (bus.err !== 1'b1) begin $display("FAIL noload_err got=%b exp=1", bus.err); n_fail++; end
        n_chk++;
        if (bus.busy !== 1'b0) begin $display("FAIL noload_busy got=%b exp=0", bus.busy); n_fail++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_frame();
        int gnt_cyc = 0;
        int n_init = 0;
        int n_done = 0;
        int rise_cyc = 0;
        logic [CNT_W-1:0] prev_win = '0;
        logic prev_rdy;
        bus.hostReq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.hostGnt) gnt_cyc++;
            if (i == 0) begin
                n_chk++;
                if (bus.hostGnt !== 1'b1) begin $display("FAIL load_gnt_rise got=%b exp=1", bus.hostGnt); n_fail++; end
            end
        end
        bus.hostReq = 1'b0;
        tick();
        n_chk++;
        if (bus.hostGnt !== 1'b0) begin $display("FAIL load_gnt_fall got=%b exp=0", bus.hostGnt); n_fail++; end
        n_chk++;
        if (gnt_cyc != 10) begin $display("FAIL load_gnt_len got=%0d exp=10", gnt_cyc); n_fail++; end

        bus.rdyHeu = 1'b1;
        bus.start  = 1'b1;
        prev_rdy   = bus.rdyIpgu;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick();
            bus.start = 1'b0;
            if (cyc == 1) begin
                n_chk++;
                if (bus.busy !== 1'b1) begin $display("FAIL frame_busy got=%b exp=1", bus.busy); n_fail++; end
            end
            if (bus.initIpgu) begin
                if (n_init == 0) begin
                    n_chk++;
                    if (cyc != 1) begin $display("FAIL start_to_init got=%0d exp=1", cyc); n_fail++; end
                end else begin
                    n_chk++;
                    if (prev_win !== 16'd3) begin $display("FAIL scale_wincnt scale=%0d got=%0d exp=3", n_init - 1, prev_win); n_fail++; end
                end
                n_chk++;
                if (bus.scaleIdx !== 3'(n_init)) begin $display("FAIL scale_idx got=%0d exp=%0d", bus.scaleIdx, n_init); n_fail++; end
                n_init++;
            end
            if (bus.rdyIpgu && !prev_rdy) rise_cyc = cyc;
            prev_rdy = bus.rdyIpgu;
            if (bus.frameDone) begin
                n_done++;
                n_chk++;
                if (cyc - rise_cyc != 2) begin $display("FAIL done_latency got=%0d exp=2", cyc - rise_cyc); n_fail++; end
                n_chk++;
                if (bus.busy !== 1'b0) begin $display("FAIL done_busy got=%b exp=0", bus.busy); n_fail++; end
            end
            prev_win = bus.winCnt;
        end
        n_chk++;
        if (n_init != 5) begin $display("FAIL init_pulses got=%0d exp=5", n_init); n_fail++; end
        n_chk++;
        if (n_done != 1) begin $display("FAIL done_pulses got=%0d exp=1", n_done); n_fail++; end
        n_chk++;
        if (bus.winCnt !== 16'd3) begin $display("FAIL final_wincnt got=%0d exp=3", bus.winCnt); n_fail++; end
        n_chk++;
        if (bus.frameWinCnt !== 16'd15) begin $display("FAIL frame_wincnt got=%0d exp=15", bus.frameWinCnt); n_fail++; end
        n_chk++;
        if (bus.err !== 1'b0) begin $display("FAIL frame_err got=%b exp=0", bus.err); n_fail++; end
    endtask

    task automatic test_lockout();
        int guard = 0;
        int gnt_busy = 0;
        bus.hostReq = 1'b1;
        repeat (3) tick();
        bus.hostReq = 1'b0;
        repeat (2) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (bus.scaleIdx != 3'd2 && guard < 100) begin tick(); guard++; end
        n_chk++;
        if (guard >= 100) begin $display("FAIL lockout_wait_scale2 got=%0d exp=2", bus.scaleIdx); n_fail++; end
        bus.hostReq = 1'b1;
        guard = 0;
        while (!bus.frameDone && guard < 100) begin
            tick();
            guard++;
            if (bus.busy && bus.hostGnt) gnt_busy++;
        end
        n_chk++;
        if (guard >= 100) begin $display("FAIL lockout_wait_done got=%b exp=1", bus.frameDone); n_fail++; end
        n_chk++;
        if (gnt_busy != 0) begin $display("FAIL lockout_gnt_busy got=%0d exp=0", gnt_busy); n_fail++; end
        n_chk++;
        if (bus.hostGnt !== 1'b0) begin $display("FAIL lockout_gnt_done got=%b exp=0", bus.hostGnt); n_fail++; end
        tick();
        n_chk++;
        if (bus.hostGnt !== 1'b0) begin $display("FAIL lockout_gnt_idle got=%b exp=0", bus.hostGnt); n_fail++; end
        tick();
        n_chk++;
        if (bus.hostGnt !== 1'b1) begin $display("FAIL lockout_gnt_served got=%b exp=1", bus.hostGnt); n_fail++; end
        bus.hostReq = 1'b0;
        repeat (2) tick();

        bus.hostReq = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        n_chk++;
        if ({bus.hostGnt, bus.initIpgu, bus.busy} !== 3'b100) begin
            $display("FAIL req_vs_start gnt/init/busy got=%b exp=100", {bus.hostGnt, bus.initIpgu, bus.busy}); n_fail++;
        end
        bus.hostReq = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        mdl_en     = 1'b0;
        t_rdy      = 1'b1;
        t_vld      = 1'b0;
        bus.rdyHeu = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_chk++;
        if (bus.initIpgu !== 1'b1) begin $display("FAIL bp_init got=%b exp=1", bus.initIpgu); n_fail++; end
        t_rdy = 1'b0;
        repeat (2) tick();
        t_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.rdyHeu = (i % 2 == 0);
            tick();
        end
        n_chk++;
        if (bus.winCnt !== 16'd4) begin $display("FAIL bp_wincnt got=%0d exp=4", bus.winCnt); n_fail++; end
        bus.rdyHeu = 1'b1;
        t_rdy      = 1'b1;
        tick();
        n_chk++;
        if ({bus.winCnt, bus.frameWinCnt} !== {16'd5, 16'd5}) begin
            $display("FAIL bp_edge_beat win=%0d fwin=%0d exp=5/5", bus.winCnt, bus.frameWinCnt); n_fail++;
        end
        bus.rdyHeu = 1'b0;
        t_vld      = 1'b0;
        tick();
        n_chk++;
        if ({bus.initIpgu, bus.scaleIdx, bus.winCnt, bus.frameWinCnt} !== {1'b1, 3'd1, 16'd0, 16'd5}) begin
            $display("FAIL bp_next_scale init=%b idx=%0d win=%0d fwin=%0d exp=1/1/0/5",
                     bus.initIpgu, bus.scaleIdx, bus.winCnt, bus.frameWinCnt); n_fail++;
        end
    endtask

    task automatic test_reset_midframe();
        t_rdy = 1'b0;
        repeat (2) tick();
        t_vld      = 1'b1;
        bus.rdyHeu = 1'b1;
        tick();
        n_chk++;
        if (bus.frameWinCnt !== 16'd6) begin $display("FAIL mid_run_fwin got=%0d exp=6", bus.frameWinCnt); n_fail++; end
        t_vld = 1'b0;
        rst   = 1'b1;
        tick();
        n_chk++;
        if ({bus.hostGnt, bus.initIpgu, bus.busy, bus.frameDone, bus.err, bus.scaleIdx, bus.winCnt, bus.frameWinCnt} !== '0) begin
            $display("FAIL mid_reset_outputs busy=%b idx=%0d win=%0d fwin=%0d err=%b expected all 0",
                     bus.busy, bus.scaleIdx, bus.winCnt, bus.frameWinCnt, bus.err); n_fail++;
        end
        rst   = 1'b0;
        t_rdy = 1'b1;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_chk++;
        if ({bus.initIpgu, bus.err} !== 2'b01) begin
            $display("FAIL mid_reset_start init/err got=%b exp=01", {bus.initIpgu, bus.err}); n_fail++;
        end
        tick();
        n_chk++;
        if (bus.busy !== 1'b0) begin $display("FAIL mid_reset_busy got=%b exp=0", bus.busy); n_fail++; end
    endtask

`ifdef SCHED_WDOG_EN
    task automatic test_wdog();
        int err_cyc = 0;
        int n_done = 0;
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        mdl_en     = 1'b1;
        mdl_hang   = 1'b1;
        bus.rdyHeu = 1'b1;
        bus.hostReq = 1'b1;
        repeat (2) tick();
        bus.hostReq = 1'b0;
        repeat (2) tick();
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            tick();
            bus.start = 1'b0;
            if (bus.frameDone) n_done++;
            if (bus.err && err_cyc == 0) err_cyc = cyc;
        end
        n_chk++;
        if (err_cyc != 103) begin $display("FAIL wdog_err_cycle got=%0d exp=103", err_cyc); n_fail++; end
        n_chk++;
        if (n_done != 0) begin $display("FAIL wdog_frame_done got=%0d exp=0", n_done); n_fail++; end
        n_chk++;
        if (bus.busy !== 1'b0) begin $display("FAIL wdog_busy got=%b exp=0", bus.busy); n_fail++; end
    endtask
`endif

    initial begin
        bus.hostReq = 1'b0;
        bus.start   = 1'b0;
        bus.rdyHeu  = 1'b0;
        test_reset();
        test_no_load();
        test_load_frame();
        test_lockout();
        test_backpressure();
        test_reset_midframe();
`ifdef SCHED_WDOG_EN
        test_wdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
